// File: rtl/tcam_pipelined.sv
// ---------------------------------------------------------------------------
// tcam_pipelined
//   Parametrised ternary CAM with per-entry valid bits, single-entry
//   invalidate, global flush and a 2-stage search pipeline. The lowest
//   matching index wins. It produces {hit, address} for the lookup and
//   classification logic.
//
// Parameters
//   WIDTH   key / entry width in bits
//   DEPTH   number of entries (>= 2)
//   ADDR_W  address width, derived from DEPTH (do not override)
//
// Optional feature
//   TCAM_MULTI_HIT_EN  when defined, adds res_multi (two or more valid entries
//                      matched) and res_vec (the raw match vector), both
//                      aligned with res_valid.
//
// Ports
//   clk         in   rising-edge clock
//   resetN      in   asynchronous active-low reset
//   wr_en       in   write entry wr_addr (data + mask), set its valid bit
//   wr_addr     in   write target; out-of-range addresses are ignored
//   wr_data     in   stored pattern
//   wr_mask     in   don't-care mask, 1 = bit ignored in compare
//   inv_en      in   clear valid bit of entry inv_addr
//   inv_addr    in   invalidate target; out-of-range addresses are ignored
//   flush       in   clear all valid bits
//   srch_valid  in   search request this cycle
//   srch_key    in   search key
//   res_valid   out  result strobe, 2 cycles after srch_valid
//   res_hit     out  at least one valid entry matched
//   res_addr    out  lowest matching index, 0 on a miss
//   res_multi   out  (TCAM_MULTI_HIT_EN) two or more entries matched
//   res_vec     out  (TCAM_MULTI_HIT_EN) raw match vector
// ---------------------------------------------------------------------------
module tcam_pipelined #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  wr_mask,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic              flush,
    input  logic              srch_valid,
    input  logic [WIDTH-1:0]  srch_key,
    output logic              res_valid,
    output logic              res_hit,
`ifdef TCAM_MULTI_HIT_EN
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_multi,
    output logic [DEPTH-1:0]  res_vec
`else
    output logic [ADDR_W-1:0] res_addr
`endif
);

    // Table storage. Data and mask are not reset: the valid bits gate them.
    logic [WIDTH-1:0]  r_mem_data [DEPTH];
    logic [WIDTH-1:0]  r_mem_mask [DEPTH];
    logic [DEPTH-1:0]  r_valid;

    // Pipeline registers
    logic [DEPTH-1:0]  r_s1_match;
    logic              r_s1_valid;
    logic              r_res_valid;
    logic              r_res_hit;
    logic [ADDR_W-1:0] r_res_addr;

    // Combinational match and encode
    logic [DEPTH-1:0]  w_match;
    logic              w_enc_hit;
    logic [ADDR_W-1:0] w_enc_addr;

    // ------------------------------------------------------------------
    // Entry data/mask write. Addresses >= DEPTH match no index, so they
    // are ignored without an explicit range check.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                r_mem_data[i] <= wr_data;
                r_mem_mask[i] <= wr_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid bits: flush beats invalidate beats write. A write and an
    // invalidate to different entries in the same cycle both take effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (inv_en && (inv_addr == ADDR_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-entry ternary compare against the current (pre-update) table.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] &
                ~|((r_mem_data[gi] ^ srch_key) & ~r_mem_mask[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: capture the match vector.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
        end else begin
            r_s1_valid <= srch_valid;
            if (srch_valid) begin
                r_s1_match <= w_match;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lowest-index priority encoder. Scanning downwards lets the lowest
    // set bit be the last assignment.
    // ------------------------------------------------------------------
    always_comb begin
        w_enc_hit  = |r_s1_match;
        w_enc_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_enc_addr = ADDR_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: result registers. Hit/address hold between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_addr  <= '0;
        end else begin
            r_res_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_hit  <= w_enc_hit;
                r_res_addr <= w_enc_addr;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_hit   = r_res_hit;
    assign res_addr  = r_res_addr;

`ifdef TCAM_MULTI_HIT_EN
    logic              w_multi;
    logic              r_res_multi;
    logic [DEPTH-1:0]  r_res_vec;

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    assign w_multi = |(r_s1_match & (r_s1_match - DEPTH'(1)));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_res_multi <= 1'b0;
            r_res_vec   <= '0;
        end else if (r_s1_valid) begin
            r_res_multi <= w_multi;
            r_res_vec   <= r_s1_match;
        end
    end

    assign res_multi = r_res_multi;
    assign res_vec   = r_res_vec;
`endif

endmodule
